cmp_operand_loader: RTL and testbench
=====================================

// Module: cmp_operand_loader
// PURPOSE
//  Upstream operand stage for the 4-bit comparison/max units. It captures X then Y from one
//  switch bank on successive presses of a load button. It holds both operands stable on
//  x_out/y_out, which drive the comparators' x/y inputs. It flags when a complete pair is present.
//  Sequencing is handled by a 3-state FSM with input synchronisers and rising-edge detection.
// PARAMETERS
//  WIDTH        4   operand width; matches the comparator x/y inputs
//  SYNC_STAGES  2   flip-flop depth of the sw/btn synchronisers (min 2)
//  CNT_WIDTH    8   width of the completed-pair counter
// PORTS
//  clk        in   1              single system clock; all state on rising edge
//  rst        in   1              asynchronous, active-high reset
//  sw         in   WIDTH          raw switch operand value (asynchronous to clk)
//  btn_load   in   1              raw, externally debounced load button (asynchronous)
//  btn_clear  in   1              raw, externally debounced clear button (asynchronous)
//  x_out      out  WIDTH          captured operand X (to comparator x)
//  y_out      out  WIDTH          captured operand Y (to comparator y)
//  x_valid    out  1              x_out holds a captured value
//  y_valid    out  1              y_out holds a captured value
//  pair_ready out  1              level: state == READY (both operands valid)
//  pair_pulse out  1              one-cycle pulse on the edge that entered READY
//  state_out  out  2              FSM state: 00 WAIT_X, 01 WAIT_Y, 10 READY (11 unused)
//  pair_count out  CNT_WIDTH      number of completed pairs, wraps
// BEHAVIOUR
//  Reset (async assert; release synchronous to clk):
//   - all outputs are 0, state = WAIT_X, and all synchroniser/edge flops are 0.
//  Synchronisers:
//   - sw, btn_load and btn_clear each pass through a SYNC_STAGES flop chain of equal depth.
//   - The captured sw value is therefore the one sampled on the same edge as the button.
//  Edge detection:
//   - load_edge = load_s & ~load_q, where load_q is load_s delayed by one cycle; same for clr_edge.
//   - Holding a button down gives exactly one edge; release gives none.
//  Latency:
//   - btn_load is first sampled high at edge E0. The capture and state change are visible
//     after edge E0+SYNC_STAGES.
//  FSM on load_edge (clr_edge=0):
//   - WAIT_X -> WAIT_Y: x_out <= sw_s; x_valid <= 1.
//   - WAIT_Y -> READY:  y_out <= sw_s; y_valid <= 1; pair_pulse = 1 for 1 cycle;
//     pair_count += 1, wrapping from 2^CNT_WIDTH-1 to 0.
//   - READY -> WAIT_Y:  x_out <= sw_s; y_valid <= 0; y_out holds its old value
//     (downstream must gate on pair_ready).
//  clr_edge:
//   - From any state -> WAIT_X; x_out, y_out, x_valid and y_valid are cleared to 0.
//   - pair_count is preserved.
//   - clr_edge and load_edge in the same cycle: clear wins and the load is dropped.
//  Other rules:
//   - No edge: hold all state; pair_pulse = 0.
//   - Illegal state 11: next edge returns to WAIT_X with the clear actions applied.
//   - Outputs are registered; x_out and y_out never change except on a capture, clear or reset.
//   - rst asserted mid-sequence (e.g. in WAIT_Y) aborts immediately; the partial X is discarded.
// TESTING
//  1. Reset, sw=4'h3, press load, then sw=4'h9, press load
//     -> x_out=3, y_out=9, state=10, pair_pulse is high for exactly 1 cycle, pair_count=1.
//  2. Hold btn_load high for 20 cycles while in WAIT_X
//     -> exactly one capture, state=01, and no second capture on the same press.
//  3. In READY, set sw=4'hF and press load
//     -> x_out=F, y_valid=0, state=01, pair_ready=0, and y_out still holds 9.
//  4. Assert btn_clear and btn_load on the same cycle in WAIT_Y
//     -> state=00, x_out=0, x_valid=0, and pair_count is unchanged.
//  5. Complete 256 pairs -> pair_count wraps to 0 and pair_pulse fires on every completion.
//  6. Assert rst asynchronously (mid-cycle) in WAIT_Y
//     -> all outputs are 0 immediately; after release, the next load captures into X.

Source files
------------

// File: rtl/cmp_operand_loader_if.sv
// Operand-loader bus: raw switch/button inputs and the registered operand/status outputs.
// The loader takes the slave side; the driver of the switches (board or bench) takes the master side.
interface cmp_operand_loader_if #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
);
  logic [WIDTH-1:0]     sw;
  logic                 btn_load;
  logic                 btn_clear;
  logic [WIDTH-1:0]     x_out;
  logic [WIDTH-1:0]     y_out;
  logic                 x_valid;
  logic                 y_valid;
  logic                 pair_ready;
  logic                 pair_pulse;
  logic [1:0]           state_out;
  logic [CNT_WIDTH-1:0] pair_count;

  modport slave (
    input  sw, btn_load, btn_clear,
    output x_out, y_out, x_valid, y_valid, pair_ready, pair_pulse, state_out, pair_count
  );

  modport master (
    output sw, btn_load, btn_clear,
    input  x_out, y_out, x_valid, y_valid, pair_ready, pair_pulse, state_out, pair_count
  );
endinterface

// File: rtl/cmp_operand_loader.sv
// Operand stage for the comparator units: captures X then Y from one switch bank on
// successive load presses, holds them stable and flags when a complete pair is present.
module cmp_operand_loader #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cmp_operand_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    WAIT_X = 2'b00,
    WAIT_Y = 2'b01,
    READY  = 2'b10
  } state_e;

  // Switches and buttons share one chain depth so sw_s is aligned with the button edge.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sw_sync_q;
  logic [SYNC_STAGES-1:0]            load_sync_q;
  logic [SYNC_STAGES-1:0]            clr_sync_q;
  logic                              load_q;
  logic                              clr_q;

  logic [WIDTH-1:0] sw_s;
  logic             load_s;
  logic             clr_s;
  logic             load_edge;
  logic             clr_edge;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic                 x_valid_q, x_valid_d;
  logic                 y_valid_q, y_valid_d;
  logic                 pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  assign sw_s      = sw_sync_q[SYNC_STAGES-1];
  assign load_s    = load_sync_q[SYNC_STAGES-1];
  assign clr_s     = clr_sync_q[SYNC_STAGES-1];
  assign load_edge = load_s & ~load_q;
  assign clr_edge  = clr_s & ~clr_q;

  // NOTE: synchroniser and edge flops are reset too, so a button held through reset
  // release is seen as a fresh press rather than being silently swallowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync_q   <= '0;
      load_sync_q <= '0;
      clr_sync_q  <= '0;
      load_q      <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage shift on the same edge.
      sw_sync_q   <= {sw_sync_q[SYNC_STAGES-2:0], bus.sw};
      load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], bus.btn_load};
      clr_sync_q  <= {clr_sync_q[SYNC_STAGES-2:0], bus.btn_clear};
      load_q      <= load_s;
      clr_q       <= clr_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_X;
      x_q       <= '0;
      y_q       <= '0;
      x_valid_q <= 1'b0;
      y_valid_q <= 1'b0;
      pulse_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      x_valid_q <= x_valid_d;
      y_valid_q <= y_valid_d;
      pulse_q   <= pulse_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold value first, so no path infers a latch.
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    x_valid_d = x_valid_q;
    y_valid_d = y_valid_q;
    pulse_d   = 1'b0;
    count_d   = count_q;

    if (clr_edge) begin
      // Clear beats a coincident load; the pair counter is deliberately kept.
      state_d   = WAIT_X;
      x_d       = '0;
      y_d       = '0;
      x_valid_d = 1'b0;
      y_valid_d = 1'b0;
    end else if (load_edge) begin
      case (state_q)
        WAIT_X: begin
          state_d   = WAIT_Y;
          x_d       = sw_s;
          x_valid_d = 1'b1;
        end
        WAIT_Y: begin
          state_d   = READY;
          y_d       = sw_s;
          y_valid_d = 1'b1;
          pulse_d   = 1'b1;
          count_d   = count_q + CNT_WIDTH'(1);
        end
        READY: begin
          // Stale y_out is left in place; consumers qualify it with pair_ready.
          state_d   = WAIT_Y;
          x_d       = sw_s;
          y_valid_d = 1'b0;
        end
        default: begin
          state_d   = WAIT_X;
          x_d       = '0;
          y_d       = '0;
          x_valid_d = 1'b0;
          y_valid_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.x_valid    = x_valid_q;
  assign bus.y_valid    = y_valid_q;
  assign bus.pair_ready = (state_q == READY);
  assign bus.pair_pulse = pulse_q;
  assign bus.state_out  = state_q;
  assign bus.pair_count = count_q;

endmodule

// File: tb/tb_cmp_operand_loader.sv
// Bench for cmp_operand_loader: a behavioural model tracks the expected outputs and a
// scoreboard holds each completed pair until the DUT reports it with pair_pulse.
`timescale 1ns/1ps
module tb_cmp_operand_loader;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] cnt;
  } pair_t;

  logic clk;
  logic rst;

  cmp_operand_loader_if #(.WIDTH(4), .CNT_WIDTH(8)) bus ();

  cmp_operand_loader #(.WIDTH(4), .SYNC_STAGES(2), .CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  pair_t sb_q[$];
  pair_t sb_item;
  int    pulses_seen = 0;
  int    pairs_exp   = 0;

  // Reference model of the loader outputs.
  logic [1:0] m_state;
  logic [3:0] m_x, m_y;
  logic       m_xv, m_yv;
  logic [7:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 2'b00;
    m_x     = '0;
    m_y     = '0;
    m_xv    = 1'b0;
    m_yv    = 1'b0;
    m_cnt   = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".state"}, 32'(bus.state_out),  32'(m_state));
    check({tag, ".x"},     32'(bus.x_out),      32'(m_x));
    check({tag, ".y"},     32'(bus.y_out),      32'(m_y));
    check({tag, ".xv"},    32'(bus.x_valid),    32'(m_xv));
    check({tag, ".yv"},    32'(bus.y_valid),    32'(m_yv));
    check({tag, ".ready"}, 32'(bus.pair_ready), 32'(m_state == 2'b10));
    check({tag, ".cnt"},   32'(bus.pair_count), 32'(m_cnt));
  endtask

  // One button press: inputs change just after a negedge, the first sampling edge is E0,
  // and the result must appear only after E0+2.
  task automatic press(input string tag, input logic do_load, input logic do_clr,
                       input logic [3:0] sw_val, input int hold, input logic [3:0] sw_after);
    pair_t e;
    bus.sw = sw_val;
    if (do_load && !do_clr && m_state == 2'b01) begin
      e.x   = m_x;
      e.y   = sw_val;
      e.cnt = m_cnt + 8'd1;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.btn_load  = do_load;
    bus.btn_clear = do_clr;
    @(negedge clk);
    check({tag, ".lat1"}, 32'(bus.state_out), 32'(m_state));
    @(negedge clk);
    check({tag, ".lat2"}, 32'(bus.state_out), 32'(m_state));
    @(negedge clk);
    if (do_clr || m_state == 2'b11) begin
      m_state = 2'b00;
      m_x = '0; m_y = '0; m_xv = 1'b0; m_yv = 1'b0;
    end else if (do_load) begin
      case (m_state)
        2'b00: begin m_x = sw_val; m_xv = 1'b1; m_state = 2'b01; end
        2'b01: begin m_y = sw_val; m_yv = 1'b1; m_state = 2'b10; m_cnt++; pairs_exp++; end
        default: begin m_x = sw_val; m_yv = 1'b0; m_state = 2'b01; end
      endcase
    end
    check_outputs({tag, ".cap"});
    bus.sw = sw_after;
    repeat (hold) @(negedge clk);
    bus.btn_load  = 1'b0;
    bus.btn_clear = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs({tag, ".rel"});
    check({tag, ".pulse_idle"}, 32'(bus.pair_pulse), 32'd0);
  endtask

  // Scoreboard consumer: every pair_pulse must match the oldest outstanding pair.
  always @(negedge clk) begin
    if (bus.pair_pulse === 1'b1) begin
      pulses_seen++;
      if (sb_q.size() == 0) begin
        check("sb.unexpected_pulse", 32'd1, 32'd0);
      end else begin
        sb_item = sb_q.pop_front();
        check("sb.x",     32'(bus.x_out),      32'(sb_item.x));
        check("sb.y",     32'(bus.y_out),      32'(sb_item.y));
        check("sb.cnt",   32'(bus.pair_count), 32'(sb_item.cnt));
        check("sb.ready", 32'(bus.pair_ready), 32'd1);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rx, ry;
    rst           = 1'b1;
    bus.sw        = '0;
    bus.btn_load  = 1'b0;
    bus.btn_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    check("reset.pulse", 32'(bus.pair_pulse), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Long hold in WAIT_X: one capture only, later switch changes ignored.
    press("hold", 1'b1, 1'b0, 4'h3, 20, 4'h5);
    check("hold.x_kept", 32'(bus.x_out), 32'h3);

    // Complete the pair 3/9.
    press("pair1", 1'b1, 1'b0, 4'h9, 2, 4'h9);
    check("pair1.cnt", 32'(bus.pair_count), 32'd1);

    // Reload X from READY: y_out keeps 9 but is no longer valid.
    press("reload", 1'b1, 1'b0, 4'hF, 2, 4'hF);
    check("reload.y_stale", 32'(bus.y_out), 32'h9);

    // Clear and load together in WAIT_Y: clear wins, counter kept.
    press("clr_load", 1'b1, 1'b1, 4'h6, 2, 4'h6);
    check("clr_load.cnt", 32'(bus.pair_count), 32'd1);

    // 255 more pairs bring the counter from 1 through the wrap to 0.
    for (int i = 0; i < 255; i++) begin
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      press("loopx", 1'b1, 1'b0, rx, 1, rx);
      press("loopy", 1'b1, 1'b0, ry, 1, ry);
    end
    check("wrap.cnt", 32'(bus.pair_count), 32'd0);

    // Clear alone from READY keeps the counter.
    press("clr_ready", 1'b0, 1'b1, 4'h2, 2, 4'h2);

    // Asynchronous reset mid-cycle while in WAIT_Y.
    press("pre_rst", 1'b1, 1'b0, 4'h7, 2, 4'h7);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.pulse", 32'(bus.pair_pulse), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    press("post_rst", 1'b1, 1'b0, 4'hA, 2, 4'hA);

    repeat (4) @(negedge clk);
    check("sb.leftover", 32'(sb_q.size()), 32'd0);
    check("sb.pulses",   32'(pulses_seen),  32'(pairs_exp));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
